updown_counter: RTL and testbench



---
 rtl/updown_counter.sv | 101 ++++++++++
 tb/tb_updown_counter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// Parametrised up/down counter with enable, synchronous clamped load and registered wrap pulse.
// Define UPDOWN_COUNTER_SAT_EN to build the saturating variant (holds at the limits, wrap tied low).
module updown_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_val,
    output logic             o_tc,
    output logic             o_wrap
);

    localparam logic [WIDTH:0]   MAX_EXT = {1'b0, MAX};
    localparam logic [WIDTH:0]   ONE_EXT = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO    = '0;

    logic [WIDTH-1:0] r_val;
    logic [WIDTH-1:0] w_val_nxt;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH:0]   w_inc;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_at_limit;

    // One extra bit keeps MAX = 2**WIDTH-1 from aliasing to zero on increment.
    assign w_inc     = {1'b0, r_val} + ONE_EXT;
    assign w_dec     = r_val - ONE_EXT[WIDTH-1:0];
    assign w_at_max  = (w_inc == (MAX_EXT + ONE_EXT));
    assign w_at_zero = (r_val == ZERO);

    assign w_load_clamped = (i_load_val > MAX) ? MAX : i_load_val;

    assign w_at_limit = i_en & ((i_up & w_at_max) | (~i_up & w_at_zero));

    always_comb begin
        w_val_nxt = r_val;
        if (i_load) begin
            w_val_nxt = w_load_clamped;
        end else if (i_en) begin
            if (i_up) begin
                if (!w_at_max) begin
                    w_val_nxt = w_inc[WIDTH-1:0];
                end else begin
`ifdef UPDOWN_COUNTER_SAT_EN
                    w_val_nxt = r_val;
`else
                    w_val_nxt = ZERO;
`endif
                end
            end else begin
                if (!w_at_zero) begin
                    w_val_nxt = w_dec;
                end else begin
`ifdef UPDOWN_COUNTER_SAT_EN
                    w_val_nxt = r_val;
`else
                    w_val_nxt = MAX;
`endif
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_val <= ZERO;
        end else begin
            r_val <= w_val_nxt;
        end
    end

`ifdef UPDOWN_COUNTER_SAT_EN
    assign o_wrap = 1'b0;
`else
    logic r_wrap;
    logic w_wrap_nxt;

    // A boundary crossing is exactly an enabled edge taken at the limit, unless load overrides it.
    assign w_wrap_nxt = w_at_limit & ~i_load;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_nxt;
        end
    end

    assign o_wrap = r_wrap;
`endif

    assign o_val = r_val;
    assign o_tc  = w_at_limit;

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: two instances (WIDTH=4, MAX=9 and MAX=15) driven with shared inputs,
// checked against directed vectors, hand sequences and an arithmetic reference model.
module tb_updown_counter;

`ifdef UPDOWN_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en, up, load;
    logic [3:0] load_val;
    logic [3:0] val_a, val_b;
    logic       tc_a, tc_b, wrap_a, wrap_b;

    int n_tests = 0;
    int n_fail  = 0;

    int mx[2] = '{9, 15};
    int m_val[2];
    bit m_wrap[2];
    logic last_tc_a, last_tc_b;

    typedef struct {
        bit       en;
        bit       up;
        bit       load;
        int       lv;
        int       exp_val;
        bit       exp_wrap;
        bit       exp_tc;
    } vec_t;

    vec_t vecs[$];

    updown_counter #(.WIDTH(4), .MAX(4'd9)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_load(load),
        .i_load_val(load_val), .o_val(val_a), .o_tc(tc_a), .o_wrap(wrap_a)
    );

    updown_counter #(.WIDTH(4), .MAX(4'd15)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_load(load),
        .i_load_val(load_val), .o_val(val_b), .o_tc(tc_b), .o_wrap(wrap_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit model_tc(input int i);
        return en && ((up && m_val[i] == mx[i]) || (!up && m_val[i] == 0));
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int v;
            v = m_val[i];
            m_wrap[i] = 1'b0;
            if (load) begin
                m_val[i] = (int'(load_val) > mx[i]) ? mx[i] : int'(load_val);
            end else if (en) begin
                if (up) begin
                    m_val[i] = SAT ? ((v + 1 > mx[i]) ? mx[i] : v + 1) : (v + 1) % (mx[i] + 1);
                    m_wrap[i] = !SAT && (v + 1 > mx[i]);
                end else begin
                    m_val[i] = SAT ? ((v == 0) ? 0 : v - 1) : (v + mx[i]) % (mx[i] + 1);
                    m_wrap[i] = !SAT && (v == 0);
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_val[i]  = 0;
            m_wrap[i] = 1'b0;
        end
    endtask

    task automatic cycle(input bit e, input bit u, input bit l, input int lv);
        @(negedge clk);
        en = e; up = u; load = l; load_val = 4'(lv);
        #1;
        last_tc_a = tc_a;
        last_tc_b = tc_b;
        check("tc_a", 32'(tc_a), 32'(model_tc(0)));
        check("tc_b", 32'(tc_b), 32'(model_tc(1)));
        @(posedge clk);
        model_edge();
        #1;
        check("val_a", 32'(val_a), 32'(m_val[0]));
        check("val_b", 32'(val_b), 32'(m_val[1]));
        check("wrap_a", 32'(wrap_a), 32'(m_wrap[0]));
        check("wrap_b", 32'(wrap_b), 32'(m_wrap[1]));
    endtask

    function automatic void add(input bit e, input bit u, input bit l, input int lv,
                                input int ev, input bit ew, input bit et);
        vec_t v;
        v.en = e; v.up = u; v.load = l; v.lv = lv;
        v.exp_val = ev; v.exp_wrap = ew; v.exp_tc = et;
        vecs.push_back(v);
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        model_reset();

        // Directed vectors against the MAX=9 instance, starting from reset.
        add(1, 1, 1, 13, 9, 0, 0);
        add(0, 0, 1, 3, 3, 0, 0);
        add(0, 0, 0, 0, 3, 0, 0);
        add(1, 1, 0, 0, 4, 0, 0);
        add(1, 1, 0, 0, 5, 0, 0);
        add(0, 1, 0, 0, 5, 0, 0);
        add(0, 1, 0, 0, 5, 0, 0);
        add(0, 1, 0, 0, 5, 0, 0);
        add(1, 1, 0, 0, 6, 0, 0);
        add(1, 0, 0, 0, 5, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, SAT ? 0 : 9, !SAT, 1);
        add(1, 0, 0, 0, SAT ? 0 : 8, 0, SAT);
        add(0, 0, 1, 9, 9, 0, 0);
        add(1, 1, 0, 0, SAT ? 9 : 0, !SAT, 1);
        add(0, 1, 0, 0, SAT ? 9 : 0, 0, 0);

        @(negedge clk);
        check("rst_val_a", 32'(val_a), 32'd0);
        check("rst_val_b", 32'(val_b), 32'd0);
        check("rst_wrap_a", 32'(wrap_a), 32'd0);
        check("rst_tc_a", 32'(tc_a), 32'd0);
        rst = 1'b0;

        foreach (vecs[k]) begin
            cycle(vecs[k].en, vecs[k].up, vecs[k].load, vecs[k].lv);
            check($sformatf("vec%0d_val", k), 32'(val_a), 32'(vecs[k].exp_val));
            check($sformatf("vec%0d_wrap", k), 32'(wrap_a), 32'(vecs[k].exp_wrap));
            check($sformatf("vec%0d_tc", k), 32'(last_tc_a), 32'(vecs[k].exp_tc));
        end

`ifndef UPDOWN_COUNTER_SAT_EN
        cycle(0, 1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1, 0, 0);
            check("upwrap_val", 32'(val_a), 32'((i + 1) % 10));
            check("upwrap_tc", 32'(last_tc_a), 32'(i == 9));
            check("upwrap_wrap", 32'(wrap_a), 32'(i == 9));
        end
        cycle(0, 1, 0, 0);
        check("upwrap_pulse_end", 32'(wrap_a), 32'd0);
        cycle(1, 0, 0, 0);
        check("dnwrap_val0", 32'(val_a), 32'd9);
        check("dnwrap_wrap0", 32'(wrap_a), 32'd1);
        cycle(1, 0, 0, 0);
        check("dnwrap_val1", 32'(val_a), 32'd8);
        check("dnwrap_wrap1", 32'(wrap_a), 32'd0);
`else
        cycle(0, 1, 1, 15);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 0);
            check("sat_hi_val", 32'(val_b), 32'd15);
            check("sat_hi_wrap", 32'(wrap_b), 32'd0);
            check("sat_hi_tc", 32'(last_tc_b), 32'd1);
        end
        cycle(0, 0, 1, 0);
        cycle(1, 0, 0, 0);
        check("sat_lo_val", 32'(val_b), 32'd0);
        check("sat_lo_tc", 32'(last_tc_b), 32'd1);
`endif

        // Asynchronous reset mid-cycle with the MAX=15 instance holding 9.
        cycle(0, 1, 1, 9);
        check("pre_rst_val_b", 32'(val_b), 32'd9);
        @(negedge clk);
        en = 1'b0; load = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_val_a", 32'(val_a), 32'd0);
        check("async_rst_val_b", 32'(val_b), 32'd0);
        check("async_rst_wrap_b", 32'(wrap_b), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        check("post_rst_hold", 32'(val_b), 32'd0);
        cycle(1, 1, 0, 0);
        check("post_rst_first", 32'(val_b), 32'd1);

        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
